// File: rtl/mdu_sequencer_if.sv
// mdu_sequencer_if
// Bundles the EX-stage request/response signals of the multiply sequencer.
//
// Handshake: Start is a one-cycle request. It takes effect only on an edge
// where Busy=0 and Abort=0. While Busy=1 the requester must hold off. The
// sequencer never back-pressures MTHI/MTLO; those complete at the sampling
// edge. Done is a one-cycle pulse marking the edge at which Hi/Lo took a
// product.
//
// Signals:
//   Start  request strobe           Op     operation code (3 bits)
//   RsVal  rs operand / MT source   RtVal  rt operand
//   Abort  pipeline flush           Busy   multiply in flight
//   Done   product written pulse    Hi/Lo  architectural HI/LO registers
//
// Modports: master = pipeline side, slave = sequencer side.
interface mdu_sequencer_if;
    logic        Start;
    logic [2:0]  Op;
    logic [31:0] RsVal;
    logic [31:0] RtVal;
    logic        Abort;
    logic        Busy;
    logic        Done;
    logic [31:0] Hi;
    logic [31:0] Lo;

    modport master (
        output Start, Op, RsVal, RtVal, Abort,
        input  Busy, Done, Hi, Lo
    );

    modport slave (
        input  Start, Op, RsVal, RtVal, Abort,
        output Busy, Done, Hi, Lo
    );
endinterface

// File: rtl/mdu_sequencer.sv
// mdu_sequencer
// Owns HI/LO and runs MULT/MULTU/MADD/MSUB as a 32-step shift-add multiply.
// MTHI/MTLO write HI/LO directly in one cycle.
//
// Ports:
//   Clk        rising-edge clock
//   Rst_n      asynchronous active-low reset
//   bus        mdu_sequencer_if.slave (Start/Op/RsVal/RtVal/Abort in,
//              Busy/Done/Hi/Lo out)
//   dbg_state  current FSM state (0=IDLE, 1=CALC, 2=WB)
module mdu_sequencer (
    input  logic              Clk,
    input  logic              Rst_n,
    mdu_sequencer_if.slave    bus,
    output logic [1:0]        dbg_state
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_WB   = 2'd2
    } state_t;

    localparam logic [1:0] OP_MULT  = 2'd0;
    localparam logic [1:0] OP_MULTU = 2'd1;
    localparam logic [1:0] OP_MADD  = 2'd2;
    localparam logic [1:0] OP_MSUB  = 2'd3;

    state_t      state_q, state_d;
    logic [31:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic [63:0] prod_q, prod_d;
    logic [63:0] base_q, base_d;
    logic        sign_q, sign_d;
    logic [1:0]  op_q, op_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;

    // Datapath helpers
    logic        is_unsigned;
    logic [31:0] rs_mag, rt_mag;
    logic [32:0] step_sum;
    logic [63:0] signed_prod;
    logic [63:0] wb_val;

    always_comb begin
        is_unsigned = (bus.Op[1:0] == OP_MULTU);
        rs_mag = (!is_unsigned && bus.RsVal[31]) ? (~bus.RsVal + 32'd1) : bus.RsVal;
        rt_mag = (!is_unsigned && bus.RtVal[31]) ? (~bus.RtVal + 32'd1) : bus.RtVal;

        // One shift-add step: the carry out of the upper-half add becomes
        // the new MSB once the product is shifted right.
        step_sum = {1'b0, prod_q[63:32]} + {1'b0, (mplier_q[0] ? mcand_q : 32'd0)};

        signed_prod = sign_q ? (64'd0 - prod_q) : prod_q;
        case (op_q)
            OP_MADD: wb_val = base_q + signed_prod;
            OP_MSUB: wb_val = base_q - signed_prod;
            default: wb_val = signed_prod;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        base_d   = base_q;
        sign_d   = sign_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Abort in IDLE drops any request on the same edge.
                if (bus.Start && !bus.Abort) begin
                    if (!bus.Op[2]) begin
                        mcand_d  = rs_mag;
                        mplier_d = rt_mag;
                        sign_d   = is_unsigned ? 1'b0 : (bus.RsVal[31] ^ bus.RtVal[31]);
                        op_d     = bus.Op[1:0];
                        base_d   = {hi_q, lo_q};
                        prod_d   = 64'd0;
                        cnt_d    = 5'd0;
                        state_d  = S_CALC;
                    end else if (bus.Op == 3'd4) begin
                        hi_d = bus.RsVal;
                    end else if (bus.Op == 3'd5) begin
                        lo_d = bus.RsVal;
                    end
                end
            end
            S_CALC: begin
                if (bus.Abort) begin
                    state_d = S_IDLE;
                end else begin
                    prod_d   = {step_sum, prod_q[31:1]};
                    mplier_d = {1'b0, mplier_q[31:1]};
                    cnt_d    = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                // Abort wins over the write-back on the same edge.
                state_d = S_IDLE;
                if (!bus.Abort) begin
                    hi_d   = wb_val[63:32];
                    lo_d   = wb_val[31:0];
                    done_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q  <= S_IDLE;
            mcand_q  <= 32'd0;
            mplier_q <= 32'd0;
            prod_q   <= 64'd0;
            base_q   <= 64'd0;
            sign_q   <= 1'b0;
            op_q     <= 2'd0;
            cnt_q    <= 5'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            base_q   <= base_d;
            sign_q   <= sign_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign bus.Busy  = (state_q != S_IDLE);
    assign bus.Done  = done_q;
    assign bus.Hi    = hi_q;
    assign bus.Lo    = lo_q;
    assign dbg_state = state_q;
endmodule

// File: tb/tb_mdu_sequencer.sv
module tb_mdu_sequencer;
  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mdu_sequencer_if bus();
  logic [1:0] dbg_state;

  mdu_sequencer dut (
    .Clk       (clk),
    .Rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];
  logic [31:0] hi_m = 32'd0;
  logic [31:0] lo_m = 32'd0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the architectural HI/LO pair.
  function automatic logic [63:0] ref_mdu(input logic [2:0] op, input logic [31:0] rs,
                                          input logic [31:0] rt, input logic [63:0] acc);
    logic signed [63:0] sa, sb;
    logic [63:0] sp, up;
    sa = {{32{rs[31]}}, rs};
    sb = {{32{rt[31]}}, rt};
    sp = sa * sb;
    up = {32'd0, rs} * {32'd0, rt};
    case (op)
      3'd0: return sp;
      3'd1: return up;
      3'd2: return acc + sp;
      3'd3: return acc - sp;
      default: return acc;
    endcase
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  // Multiply op. abort_at/junk_at = cycle after Start (1..33) at which Abort or
  // a stray Start is driven; 0 disables.
  task automatic run_mul(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                         input int abort_at, input int junk_at);
    logic [63:0] exp;
    logic [63:0] got;
    int busy_n;
    bit seen_done;
    exp_q.push_back(ref_mdu(op, rs, rt, {hi_m, lo_m}));
    @(negedge clk);
    bus.Start = 1'b1; bus.Op = op; bus.RsVal = rs; bus.RtVal = rt;
    @(negedge clk);
    bus.Start = 1'b0; bus.Op = 3'($urandom); bus.RsVal = $urandom; bus.RtVal = $urandom;
    busy_n = 0;
    seen_done = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (bus.Done) begin
        seen_done = 1'b1;
        break;
      end
      if (bus.Busy) busy_n++;
      else break;
      if (c == junk_at) begin
        bus.Start = 1'b1; bus.Op = 3'($urandom); bus.RsVal = $urandom; bus.RtVal = $urandom;
      end
      if (c == abort_at) bus.Abort = 1'b1;
      @(negedge clk);
      bus.Start = 1'b0;
      bus.Abort = 1'b0;
    end
    exp = exp_q.pop_front();
    if (abort_at == 0) begin
      check("mul_busy_cycles", 64'(busy_n), 64'd33);
      check("mul_done_seen", {63'd0, seen_done}, 64'd1);
      got = {bus.Hi, bus.Lo};
      check("mul_hilo", got, exp);
      hi_m = exp[63:32];
      lo_m = exp[31:0];
      @(negedge clk);
      check("mul_done_pulse", {63'd0, bus.Done}, 64'd0);
      check("mul_busy_after", {63'd0, bus.Busy}, 64'd0);
    end else begin
      check("abort_busy_cycles", 64'(busy_n), 64'(abort_at));
      check("abort_no_done", {63'd0, seen_done}, 64'd0);
      for (int i = 0; i < 3; i++) begin
        check("abort_done_low", {63'd0, bus.Done}, 64'd0);
        check("abort_hilo", {bus.Hi, bus.Lo}, {hi_m, lo_m});
        @(negedge clk);
      end
    end
  endtask

  // MTHI/MTLO/no-op; abort=1 drives Abort with the request so it is dropped.
  task automatic run_mt(input logic [2:0] op, input logic [31:0] val, input bit abort);
    @(negedge clk);
    bus.Start = 1'b1; bus.Op = op; bus.RsVal = val; bus.RtVal = $urandom; bus.Abort = abort;
    @(negedge clk);
    bus.Start = 1'b0; bus.Abort = 1'b0;
    if (!abort && op == 3'd4) hi_m = val;
    if (!abort && op == 3'd5) lo_m = val;
    check("mt_busy", {63'd0, bus.Busy}, 64'd0);
    check("mt_done", {63'd0, bus.Done}, 64'd0);
    check("mt_hi", {32'd0, bus.Hi}, {32'd0, hi_m});
    check("mt_lo", {32'd0, bus.Lo}, {32'd0, lo_m});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.Start = 1'b0; bus.Op = 3'd0; bus.RsVal = 32'd0; bus.RtVal = 32'd0; bus.Abort = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", {63'd0, bus.Busy}, 64'd0);
    check("rst_done", {63'd0, bus.Done}, 64'd0);
    check("rst_hilo", {bus.Hi, bus.Lo}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases from the feature list.
    run_mul(3'd0, 32'hFFFF_FFFE, 32'd3, 0, 0);
    check("mult_const", {bus.Hi, bus.Lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    run_mul(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    check("multu_const", {bus.Hi, bus.Lo}, 64'hFFFF_FFFE_0000_0001);
    run_mt(3'd4, 32'd0, 1'b0);
    run_mt(3'd5, 32'h10, 1'b0);
    run_mul(3'd2, 32'd5, 32'hFFFF_FFFD, 0, 0);
    check("madd_const", {bus.Hi, bus.Lo}, 64'h0000_0000_0000_0001);
    run_mt(3'd4, 32'd0, 1'b0);
    run_mt(3'd5, 32'd0, 1'b0);
    run_mul(3'd3, 32'd2, 32'd3, 0, 0);
    check("msub_const", {bus.Hi, bus.Lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    run_mul(3'd0, 32'd7, 32'd9, 12, 0);
    run_mul(3'd0, 32'd7, 32'd9, 0, 5);
    check("junk_const", {bus.Hi, bus.Lo}, 64'd63);
    run_mul(3'd1, 32'd11, 32'd13, 33, 0);
    run_mt(3'd6, 32'hDEAD_BEEF, 1'b0);
    run_mt(3'd7, 32'hDEAD_BEEF, 1'b0);
    run_mt(3'd4, 32'hCAFE_F00D, 1'b1);

    // Reset asserted in the middle of CALC.
    run_mt(3'd4, 32'h1234_5678, 1'b0);
    @(negedge clk);
    bus.Start = 1'b1; bus.Op = 3'd0; bus.RsVal = 32'd100; bus.RtVal = 32'd200;
    @(negedge clk);
    bus.Start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rstmid_busy", {63'd0, bus.Busy}, 64'd0);
    check("rstmid_done", {63'd0, bus.Done}, 64'd0);
    check("rstmid_hilo", {bus.Hi, bus.Lo}, 64'd0);
    hi_m = 32'd0;
    lo_m = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    run_mul(3'd0, 32'hFFFF_FFF9, 32'd6, 0, 0);

    // Randomized sequence.
    for (int n = 0; n < 40; n++) begin
      logic [2:0] op;
      int ab, jk;
      op = 3'($urandom_range(0, 7));
      if (op < 3'd4) begin
        ab = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 33) : 0;
        jk = (ab == 0 && $urandom_range(0, 3) == 0) ? $urandom_range(1, 32) : 0;
        run_mul(op, pick_operand(), pick_operand(), ab, jk);
      end else begin
        run_mt(op, pick_operand(), ($urandom_range(0, 5) == 0));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
